// File: rtl/bsg_trace_replay_sequencer.sv
// -----------------------------------------------------------------------------
// bsg_trace_replay_sequencer
//
// Drives a bank of trace-replay engines through one test run. Each engine is
// held in reset with its enable low until its phase comes up. Engines run
// either one after another (serial) or all together (parallel). A per-phase
// watchdog bounds how long a phase may run. The first failure is captured,
// and a single pass/fail verdict is presented once the run is over.
//
// Parameters
//   num_replay_p     number of engines controlled (>= 1)
//   parallel_p       0 = serial phases, 1 = all engines in one phase
//   timeout_width_p  width of the watchdog budget and of the RUN cycle counter
//   idx_width_lp     engine index width, $clog2(num_replay_p) with a floor of 1
//
// Ports
//   clk_i           clock
//   reset_n_i       synchronous active-low reset
//   start_i         start a run (honoured in IDLE and FINISHED only)
//   timeout_i       per-phase watchdog budget in RUN cycles, 0 = disabled
//   replay_done_i   engine done levels (sticky until that engine is reset)
//   replay_error_i  engine error levels (sticky)
//   replay_reset_o  active-high reset to each engine
//   replay_en_o     enable to each engine
//   busy_o          high in CLEAR and RUN
//   done_o          high in FINISHED
//   pass_o          high in FINISHED when no failure was captured
//   phase_idx_o     engine currently sequenced (always 0 in parallel mode)
//   fail_idx_o      engine that failed, meaningful when fail_cause_o != 0
//   fail_cause_o    0 = none, 1 = engine error, 2 = watchdog timeout
//   cycle_cnt_o     RUN cycles in the current/last run, saturating
// -----------------------------------------------------------------------------
module bsg_trace_replay_sequencer #(
   parameter int num_replay_p    = 4,
   parameter int parallel_p      = 0,
   parameter int timeout_width_p = 24,
   parameter int idx_width_lp    = (num_replay_p > 1) ? $clog2(num_replay_p) : 1
) (
   input  logic                       clk_i,
   input  logic                       reset_n_i,
   input  logic                       start_i,
   input  logic [timeout_width_p-1:0] timeout_i,
   input  logic [num_replay_p-1:0]    replay_done_i,
   input  logic [num_replay_p-1:0]    replay_error_i,
   output logic [num_replay_p-1:0]    replay_reset_o,
   output logic [num_replay_p-1:0]    replay_en_o,
   output logic                       busy_o,
   output logic                       done_o,
   output logic                       pass_o,
   output logic [idx_width_lp-1:0]    phase_idx_o,
   output logic [idx_width_lp-1:0]    fail_idx_o,
   output logic [1:0]                 fail_cause_o,
   output logic [timeout_width_p-1:0] cycle_cnt_o
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_CLEAR    = 2'd1,
      S_RUN      = 2'd2,
      S_FINISHED = 2'd3
   } state_e;

   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_ERROR   = 2'd1;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

   // ---------------------------------------------------------------------------
   // State and result registers
   // ---------------------------------------------------------------------------
   state_e                     state_q,      state_d;
   logic [idx_width_lp-1:0]    cur_idx_q,    cur_idx_d;
   logic [timeout_width_p-1:0] wdog_q,       wdog_d;
   logic [timeout_width_p-1:0] cycle_cnt_q,  cycle_cnt_d;
   logic [idx_width_lp-1:0]    fail_idx_q,   fail_idx_d;
   logic [1:0]                 fail_cause_q, fail_cause_d;

   // Output registers, loaded from the next-state decode so that every output
   // is a flop yet still reflects the current state exactly.
   logic [num_replay_p-1:0]    replay_en_q,    replay_en_d;
   logic [num_replay_p-1:0]    replay_reset_q, replay_reset_d;
   logic                       busy_q,         busy_d;
   logic                       done_q,         done_d;
   logic                       pass_q,         pass_d;

   // ---------------------------------------------------------------------------
   // Engine selection masks. In parallel mode every engine is selected; in
   // serial mode only the one matching the phase index. Expressing both modes
   // as a mask lets the done/error/timeout logic below be shared.
   // ---------------------------------------------------------------------------
   logic [num_replay_p-1:0] sel_q;   // engines of the phase now running
   logic [num_replay_p-1:0] sel_d;   // engines of the phase about to be entered

   for (genvar gi = 0; gi < num_replay_p; gi++) begin : g_sel
      assign sel_q[gi] = (parallel_p != 0) || (cur_idx_q == idx_width_lp'(gi));
      assign sel_d[gi] = (parallel_p != 0) || (cur_idx_d == idx_width_lp'(gi));
   end

   // Error on any selected engine (serial: just the current one).
   logic err_hit;
   // All selected engines done. Unselected bits are forced to 1 so the AND
   // collapses to a single bit test in serial mode.
   logic done_hit;
   // Final phase of the run: always true in parallel mode.
   logic last_phase;

   assign err_hit    = |(replay_error_i & sel_q);
   assign done_hit   = &(replay_done_i | ~sel_q);
   assign last_phase = (parallel_p != 0) ||
                       (cur_idx_q == idx_width_lp'(num_replay_p - 1));

   // Index of the lowest set bit, 0 when none is set.
   function automatic logic [idx_width_lp-1:0] lowest_set(
      input logic [num_replay_p-1:0] vec
   );
      logic [idx_width_lp-1:0] r;
      r = '0;
      for (int i = num_replay_p - 1; i >= 0; i--) begin
         if (vec[i]) begin
            r = idx_width_lp'(i);
         end
      end
      return r;
   endfunction

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      cur_idx_d    = cur_idx_q;
      wdog_d       = wdog_q;
      cycle_cnt_d  = cycle_cnt_q;
      fail_idx_d   = fail_idx_q;
      fail_cause_d = fail_cause_q;

      case (state_q)
         S_IDLE, S_FINISHED: begin
            if (start_i) begin
               state_d      = S_CLEAR;
               cur_idx_d    = '0;
               cycle_cnt_d  = '0;
               fail_idx_d   = '0;
               fail_cause_d = CAUSE_NONE;
            end
         end

         S_CLEAR: begin
            // Each phase gets a fresh budget.
            wdog_d  = timeout_i;
            state_d = S_RUN;
         end

         S_RUN: begin
            if (cycle_cnt_q != '1) begin
               cycle_cnt_d = cycle_cnt_q + timeout_width_p'(1);
            end
            if (wdog_q != '0) begin
               wdog_d = wdog_q - timeout_width_p'(1);
            end

            // Priority: error, then done, then watchdog. A done on the very
            // cycle the budget runs out therefore still counts as success.
            if (err_hit) begin
               state_d      = S_FINISHED;
               fail_cause_d = CAUSE_ERROR;
               fail_idx_d   = lowest_set(replay_error_i & sel_q);
            end else if (done_hit) begin
               if (last_phase) begin
                  state_d = S_FINISHED;
               end else begin
                  cur_idx_d = cur_idx_q + idx_width_lp'(1);
                  state_d   = S_CLEAR;
               end
            end else if (wdog_q == timeout_width_p'(1)) begin
               // A zero budget never reaches 1, so the watchdog stays off.
               state_d      = S_FINISHED;
               fail_cause_d = CAUSE_TIMEOUT;
               fail_idx_d   = lowest_set(~replay_done_i & sel_q);
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output decode of the next state
   // ---------------------------------------------------------------------------
   for (genvar gi = 0; gi < num_replay_p; gi++) begin : g_out
      assign replay_en_d[gi]    = (state_d == S_RUN) && sel_d[gi];
      assign replay_reset_d[gi] = !replay_en_d[gi];
   end

   assign busy_d = (state_d == S_CLEAR) || (state_d == S_RUN);
   assign done_d = (state_d == S_FINISHED);
   assign pass_d = (state_d == S_FINISHED) && (fail_cause_d == CAUSE_NONE);

   // ---------------------------------------------------------------------------
   // Sequential state
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q        <= S_IDLE;
         cur_idx_q      <= '0;
         wdog_q         <= '0;
         cycle_cnt_q    <= '0;
         fail_idx_q     <= '0;
         fail_cause_q   <= CAUSE_NONE;
         replay_en_q    <= '0;
         replay_reset_q <= '1;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         pass_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         cur_idx_q      <= cur_idx_d;
         wdog_q         <= wdog_d;
         cycle_cnt_q    <= cycle_cnt_d;
         fail_idx_q     <= fail_idx_d;
         fail_cause_q   <= fail_cause_d;
         replay_en_q    <= replay_en_d;
         replay_reset_q <= replay_reset_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         pass_q         <= pass_d;
      end
   end

   assign replay_en_o    = replay_en_q;
   assign replay_reset_o = replay_reset_q;
   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign pass_o         = pass_q;
   assign phase_idx_o    = cur_idx_q;   // held at 0 throughout in parallel mode
   assign fail_idx_o     = fail_idx_q;
   assign fail_cause_o   = fail_cause_q;
   assign cycle_cnt_o    = cycle_cnt_q;

endmodule

// File: doc/bsg_trace_replay_sequencer.md
# bsg_trace_replay_sequencer

Sequences a bank of `num_replay_p` trace-replay engines through a test run. It holds each engine in reset and gates its enable, runs the engines one after another (serial) or all together (parallel), and applies a per-phase watchdog. It also records the first failure and reports a single pass/fail verdict with the failing index and cause. It sits in the testbench between the top-level test control and the replay engines' `reset_i`/`en_i`/`done_o`/`error_o` pins.

## Interface
- `num_replay_p`, default 4: number of replay engines controlled; minimum 1.
- `parallel_p`, default 0: 0 = serial (engine 0, then 1, ...); 1 = all engines run simultaneously.
- `timeout_width_p`, default 24: width of the watchdog budget and of the cycle counter.
- `idx_width_lp`, derived: `$clog2(num_replay_p)`, minimum 1.
- `clk_i`  in  1  clock. The block has one clock.
- `reset_n_i`  in  1  reset; synchronous, active-low.
- `start_i`  in  1  starts a run; sampled only in IDLE or FINISHED.
- `timeout_i`  in  timeout_width_p  per-phase watchdog budget in RUN cycles; 0 disables the watchdog; sampled on each CLEAR entry.
- `replay_done_i`  in  num_replay_p  engine `done_o` (level, sticky until that engine is reset).
- `replay_error_i`  in  num_replay_p  engine `error_o` (level, sticky).
- `replay_reset_o`  out  num_replay_p  active-high reset to each engine.
- `replay_en_o`  out  num_replay_p  enable to each engine.
- `busy_o`  out  1  high in CLEAR and RUN.
- `done_o`  out  1  high in FINISHED.
- `pass_o`  out  1  high in FINISHED when no failure was recorded.
- `phase_idx_o`  out  idx_width_lp  current engine index (serial); 0 in parallel mode.
- `fail_idx_o`  out  idx_width_lp  index of the failing engine; valid when `fail_cause_o != 0`.
- `fail_cause_o`  out  2  0 = none, 1 = engine error, 2 = watchdog timeout.
- `cycle_cnt_o`  out  timeout_width_p  total RUN cycles in the current/last run; saturates at all-ones.

## Operation
- States: IDLE, CLEAR, RUN, FINISHED. All outputs are Moore, decoded from registered state.
- IDLE:
  - `replay_reset_o` = all 1, `replay_en_o` = 0.
  - `start_i` -> CLEAR. The same transition sets `cur_idx` = 0 and clears `cycle_cnt`, `fail_idx` and `fail_cause`.
- CLEAR (exactly 1 cycle):
  - Selected engines have `replay_reset_o` = 1, `replay_en_o` = 0. Selected = `cur_idx` (serial) or all (parallel).
  - The watchdog is loaded with `timeout_i`.
  - Next state is RUN.
- RUN:
  - Selected engines have `replay_reset_o` = 0 and `replay_en_o` = 1. Non-selected engines have reset 1 and enable 0.
  - `cycle_cnt` increments (saturating) each RUN cycle.
  - The watchdog decrements each RUN cycle while it is nonzero.
- RUN exits are evaluated in priority order, on the same cycle:
  1. Error (serial: `replay_error_i[cur_idx]`; parallel: any bit) -> FINISHED with cause 1. In parallel mode `fail_idx` = lowest erroring index.
  2. Done (serial: `replay_done_i[cur_idx]`; parallel: all bits set):
     - Serial with `cur_idx` < N-1: increment `cur_idx` -> CLEAR.
     - Otherwise -> FINISHED, pass.
  3. Watchdog: budget nonzero and watchdog == 1 at the start of this cycle -> FINISHED with cause 2. `fail_idx` = `cur_idx` (serial) or the lowest not-done index (parallel).
- FINISHED:
  - `replay_en_o` = 0, `replay_reset_o` = all 1. Result registers hold.
  - `start_i` -> CLEAR: new run from index 0, results cleared.
- `start_i` is ignored in CLEAR and RUN.
- Engine inputs are ignored outside RUN.
- Only the first failure is recorded; a run never continues past a failure.

## Timing
- Reset (`reset_n_i` = 0 at a rising edge): state IDLE, `cur_idx` 0, watchdog 0, `cycle_cnt` 0. Outputs: `replay_reset_o` all 1, `replay_en_o` 0, `busy_o` 0, `done_o` 0, `pass_o` 0, `phase_idx_o` 0, `fail_idx_o` 0, `fail_cause_o` 0, `cycle_cnt_o` 0.
- Reset mid-run aborts immediately to IDLE. No result is retained.
- `start_i` high at edge t gives CLEAR during cycle t+1 and RUN from cycle t+2.
- Serial phase handoff costs exactly one CLEAR cycle between consecutive RUN phases.
- A done or error seen in RUN cycle k gives FINISHED (or CLEAR) in cycle k+1. `done_o` rises in cycle k+1.
- A budget of B gives timeout detection on the B-th RUN cycle of the phase, unless done or error is seen on that same cycle.
- `start_i` sampled in FINISHED behaves identically to IDLE; back-to-back runs are allowed.

## Test plan
- Serial, N=4, timeout 0; each engine raises done 5 RUN cycles after its reset releases:
  - `replay_reset_o` walks 0→1→2→3 with one CLEAR cycle between phases.
  - Result: `done_o`=1, `pass_o`=1, `fail_cause_o`=0, `cycle_cnt_o`=20.
- Serial, N=4; engine 2 raises error and done on the same cycle:
  - Result: FINISHED next cycle, `pass_o`=0, `fail_cause_o`=1, `fail_idx_o`=2.
  - Engine 3 never sees `replay_en_o`=1.
- Serial, `timeout_i`=8; engine 1 never raises done:
  - FINISHED after exactly 8 RUN cycles of phase 1.
  - Result: `fail_cause_o`=2, `fail_idx_o`=1.
  - Repeat with done on the 8th cycle: done wins, run continues.
- Parallel, N=4; engines finish at cycles 3/7/5/9, engines 1 and 3 erroring on the same cycle:
  - All enables rise together.
  - Error case: `fail_idx_o`=1, `fail_cause_o`=1.
  - No-error case: pass after cycle 9.
- Start handling:
  - `reset_n_i` dropped during RUN of phase 2: next cycle IDLE, all reset outputs high, results 0.
  - `start_i` pulsed during RUN: ignored.
  - `start_i` in FINISHED: clean restart at index 0.
